risc_req_arbiter: RTL

Two-requester scheduler that shares one RISC datapath (operand inputs A/B, Asel select, 16-bit memory address, 32-bit mdata result) between independent clients. It accepts a command from one requester at a time and drives the datapath inputs stable for LAT cycles. It then captures mdata and returns it, tagged with the requester ID, over a valid/ready response channel. It sits between the bus-side clients and the RISC core.

---
 rtl/risc_req_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/risc_req_arbiter.sv
// ---------------------------------------------------------------------------
// risc_req_arbiter
//
// Shares one RISC datapath between two independent requesters. One command
// is accepted at a time; its operands are driven onto the datapath and held
// stable for LAT cycles. The datapath result (mdata) is then captured and
// returned with the owning requester ID over a valid/ready response channel.
//
// Operation sequence: IDLE (grant) -> RUN (wait LAT cycles) -> RESP (hold
// the response until it is consumed) -> IDLE.
//
// Parameters:
//   LAT  datapath cycles from operand issue to a valid mdata sample (1..15)
//   AW   datapath address width
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   reqN_valid / reqN_ready   command handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b            operands A and B for requester N
//   reqN_asel, reqN_addr      A-select and memory address for requester N
//   rsp_valid / rsp_ready     response handshake
//   rsp_id, rsp_data          owning requester and captured mdata
//   risc_a, risc_b            operands driven to the datapath
//   risc_asel, risc_add       A-select and address driven to the datapath
//   risc_mdata                result returned by the datapath
//   busy                      high whenever an operation is in flight
//
// Configuration macro:
//   FIXED_PRIO_EN  when defined, requester 0 always wins when both requesters
//                  are valid; when undefined, contention is resolved
//                  round-robin.
// ---------------------------------------------------------------------------
module risc_req_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [31:0]   req0_a,
    input  logic [31:0]   req0_b,
    input  logic          req0_asel,
    input  logic [AW-1:0] req0_addr,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [31:0]   req1_a,
    input  logic [31:0]   req1_b,
    input  logic          req1_asel,
    input  logic [AW-1:0] req1_addr,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [31:0]   rsp_data,

    output logic [31:0]   risc_a,
    output logic [31:0]   risc_b,
    output logic          risc_asel,
    output logic [AW-1:0] risc_add,
    input  logic [31:0]   risc_mdata,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter load value: the counter reaches zero on the edge that samples
    // mdata, so an acceptance at edge k samples at edge k+LAT.
    localparam logic [3:0] LAT_INIT = 4'(LAT - 1);

    state_t        state_q;
    logic [3:0]    lat_cnt_q;
`ifndef FIXED_PRIO_EN
    logic          rr_ptr_q;
`endif

    logic [31:0]   risc_a_q;
    logic [31:0]   risc_b_q;
    logic          risc_asel_q;
    logic [AW-1:0] risc_add_q;

    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic [31:0]   rsp_data_q;

    logic          sel1_d;
    logic          take0_d;
    logic          take1_d;
    logic          xfer_d;
    logic [31:0]   grant_a_d;
    logic [31:0]   grant_b_d;
    logic          grant_asel_d;
    logic [AW-1:0] grant_addr_d;

    // Requester selection and payload steering. Ready is only offered in
    // IDLE and only to the selected requester, and it is gated with that
    // requester's valid so a transfer is simply "ready is high".
    always_comb begin
        sel1_d = 1'b0;
`ifdef FIXED_PRIO_EN
        sel1_d = req1_valid && !req0_valid;
`else
        sel1_d = req1_valid && (!req0_valid || rr_ptr_q);
`endif
        take0_d = (state_q == IDLE) && req0_valid && !sel1_d;
        take1_d = (state_q == IDLE) && sel1_d;
        xfer_d  = take0_d || take1_d;

        grant_a_d    = sel1_d ? req1_a    : req0_a;
        grant_b_d    = sel1_d ? req1_b    : req0_b;
        grant_asel_d = sel1_d ? req1_asel : req0_asel;
        grant_addr_d = sel1_d ? req1_addr : req0_addr;
    end

    // Control FSM with all outputs registered. The datapath operand
    // registers are only written on acceptance, so they keep their last
    // values between operations. A reset clears everything, including any
    // response still waiting in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 4'd0;
`ifndef FIXED_PRIO_EN
            rr_ptr_q    <= 1'b0;
`endif
            risc_a_q    <= 32'd0;
            risc_b_q    <= 32'd0;
            risc_asel_q <= 1'b0;
            risc_add_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer_d) begin
                        risc_a_q    <= grant_a_d;
                        risc_b_q    <= grant_b_d;
                        risc_asel_q <= grant_asel_d;
                        risc_add_q  <= grant_addr_d;
                        rsp_id_q    <= take1_d;
`ifndef FIXED_PRIO_EN
                        // Favour the other requester on the next contention.
                        rr_ptr_q    <= ~take1_d;
`endif
                        lat_cnt_q   <= LAT_INIT;
                        state_q     <= RUN;
                    end
                end

                RUN: begin
                    if (lat_cnt_q == 4'd0) begin
                        rsp_data_q  <= risc_mdata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end

                RESP: begin
                    // No bypass back into a grant on the same edge: the next
                    // acceptance happens from IDLE one edge later at best.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = take0_d;
    assign req1_ready = take1_d;

    assign risc_a    = risc_a_q;
    assign risc_b    = risc_b_q;
    assign risc_asel = risc_asel_q;
    assign risc_add  = risc_add_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    assign busy = (state_q != IDLE);

endmodule
